// File: rtl/testchain_bist_if.sv
// Control/status bundle for the flop/inverter test-chain monitor.
// master drives stimulus controls; slave is the monitor itself.
interface testchain_bist_if #(
  parameter int CH   = 2,
  parameter int RUNW = 8,
  parameter int CW   = 8
);
  logic            start;
  logic [1:0]      mode;
  logic [RUNW-1:0] run_len;
  logic            din;
  logic            inj_err;
  logic [CH-1:0]   dout;
  logic            busy;
  logic            done;
  logic            fail;
  logic [CW-1:0]   err_cnt;
  logic [CH-1:0]   err_ch;

  modport master (
    output start, mode, run_len, din, inj_err,
    input  dout, busy, done, fail, err_cnt, err_ch
  );

  modport slave (
    input  start, mode, run_len, din, inj_err,
    output dout, busy, done, fail, err_cnt, err_ch
  );
endinterface

// File: rtl/testchain_bist.sv
// Multi-channel flop/inverter test chain with built-in stimulus generator and checker.
// Each chain is N reset flops separated by D kept inverter pairs; outputs compared to a delayed reference.
module testchain_bist #(
  parameter int N    = 8,
  parameter int CH   = 2,
  parameter int D    = 1,
  parameter int RUNW = 8,
  parameter int CW   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  testchain_bist_if.slave       bus
);

  localparam int NW   = $clog2(N + 1);
  localparam int CNTW = (RUNW > NW) ? RUNW : NW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FILL,
    S_RUN,
    S_DONE
  } state_t;

  state_t              state;
  logic [CNTW-1:0]     cnt;
  logic [1:0]          mode_q;
  logic [RUNW-1:0]     len_q;
  logic [6:0]          lfsr;
  logic                tog;
  logic [N-1:0]        hist;
  logic [CW-1:0]       err_cnt;
  logic [CH-1:0]       err_ch;
  logic                busy_r;
  logic                done_r;
  logic                fail_r;

  logic [CH-1:0][N-1:0] chain_q;
  logic [CH-1:0][N-1:0] chain_d;

  logic                run;
  logic                active;
  logic                ring_run;
  logic                src;
  logic [CH-1:0]       inj;
  logic [CH-1:0]       mismatch;
  logic [CW-1:0]       err_nxt;

  // Source bit, per-channel injection and checker for the current cycle.
  always_comb begin
    run      = (state == S_RUN);
    active   = (state == S_FILL) || run;
    ring_run = run && (mode_q == 2'b11);
    src      = 1'b0;
    case (mode_q)
      2'b00:   src = bus.din;
      2'b01:   src = lfsr[6];
      2'b10:   src = ~tog;
      default: src = ring_run ? hist[N-1] : lfsr[6];
    endcase
    inj      = '0;
    mismatch = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      if (active) begin
        inj[c] = ring_run ? chain_q[c][N-1] : (src ^ c[0]);
        if (c == 0) inj[c] = inj[c] ^ bus.inj_err;
      end
      mismatch[c] = run && (chain_q[c][N-1] != (hist[N-1] ^ c[0]));
    end
    err_nxt = err_cnt;
    if ((|mismatch) && (err_cnt != '1)) err_nxt = err_cnt + CW'(1);
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    assign chain_d[c][0] = inj[c];
    assign bus.dout[c]   = chain_q[c][N-1];
    for (genvar s = 1; s < N; s++) begin : g_st
      for (genvar p = 0; p < D; p++) begin : g_pair
        (* keep = "true" *) logic inv_a;
        (* keep = "true" *) logic inv_b;
        if (p == 0) begin : g_head
          assign inv_a = ~chain_q[c][s-1];
        end else begin : g_link
          assign inv_a = ~g_pair[p-1].inv_b;
        end
        assign inv_b = ~inv_a;
      end
      assign chain_d[c][s] = g_pair[D-1].inv_b;
    end
  end

  // Chain flops are only cleared by reset; FILL flushes whatever they held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain_q <= '0;
    else        chain_q <= chain_d;
  end

  // ARM absorbs the start edge so busy rises one cycle after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      mode_q  <= '0;
      len_q   <= '0;
      lfsr    <= '0;
      tog     <= 1'b0;
      hist    <= '0;
      err_cnt <= '0;
      err_ch  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      fail_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state   <= S_ARM;
            mode_q  <= bus.mode;
            len_q   <= bus.run_len;
            lfsr    <= 7'h01;
            tog     <= 1'b0;
            hist    <= '0;
            err_cnt <= '0;
            err_ch  <= '0;
            fail_r  <= 1'b0;
            done_r  <= 1'b0;
            cnt     <= '0;
          end
        end
        S_ARM: begin
          state  <= S_FILL;
          busy_r <= 1'b1;
          cnt    <= '0;
        end
        S_FILL: begin
          lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
          tog  <= src;
          hist <= {hist[N-2:0], src};
          if (cnt == CNTW'(N - 1)) begin
            cnt <= '0;
            if (len_q == '0) begin
              state  <= S_DONE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        S_RUN: begin
          lfsr    <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
          tog     <= src;
          hist    <= {hist[N-2:0], src};
          err_cnt <= err_nxt;
          err_ch  <= err_ch | mismatch;
          fail_r  <= (err_nxt != '0);
          if ((cnt + CNTW'(1)) == CNTW'(len_q)) begin
            state  <= S_DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.fail    = fail_r;
  assign bus.err_cnt = err_cnt;
  assign bus.err_ch  = err_ch;

endmodule
